// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal ring NIC: register map, VC bit and status-bit position.
package cardinal_nic_pkg;

    localparam int DATA_WIDTH_DEFAULT = 64;
    localparam int VC_BIT             = DATA_WIDTH_DEFAULT - 1;
    localparam int STAT_BIT           = 0;

    localparam logic [1:0] ADDR_RX_BUF  = 2'b00;
    localparam logic [1:0] ADDR_RX_STAT = 2'b01;
    localparam logic [1:0] ADDR_TX_BUF  = 2'b10;
    localparam logic [1:0] ADDR_TX_STAT = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// One-packet channel buffer with a full flag; load fills, clear empties the flag only.
module nic_chan_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    logic [WIDTH-1:0] data_reg;
    logic             full_reg;

    // Data is kept on clear so an empty read still returns the last packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (load) begin
            data_reg <= d;
            full_reg <= 1'b1;
        end else if (clear) begin
            full_reg <= 1'b0;
        end
    end

    assign q    = data_reg;
    assign full = full_reg;

endmodule

// File: rtl/cardinal_nic.sv
// NIC joining a processor to a ring router PE port: rx/tx one-packet buffers behind a 4-register map.
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic                  rx_full;
    logic                  tx_full;
    logic                  rd_en;
    logic                  wr_en;
    logic                  rx_load;
    logic                  rx_clear;
    logic                  tx_load;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;

    assign rx_load  = net_si & ~rx_full;
    assign rx_clear = rd_en & (addr == ADDR_RX_BUF);
    // tx_full is sampled before the edge, so a write racing a drain is dropped.
    assign tx_load  = wr_en & (addr == ADDR_TX_BUF) & ~tx_full;

    nic_chan_buf #(.WIDTH(DATA_WIDTH)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .load  (rx_load),
        .clear (rx_clear),
        .d     (net_di),
        .q     (rx_q),
        .full  (rx_full)
    );

    nic_chan_buf #(.WIDTH(DATA_WIDTH)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load),
        .clear (net_so),
        .d     (d_in),
        .q     (tx_q),
        .full  (tx_full)
    );

    assign net_ri = ~rx_full;
    // Inject only on the VC the router currently allows (VC bit must differ from polarity).
    assign net_so = tx_full & net_ro & (tx_q[DATA_WIDTH-1] != net_polarity);
    assign net_do = tx_full ? tx_q : '0;

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (addr)
                ADDR_RX_BUF:  d_out = rx_q;
                ADDR_RX_STAT: d_out[STAT_BIT] = rx_full;
                ADDR_TX_STAT: d_out[STAT_BIT] = tx_full;
                default:      d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed scoreboard bench for cardinal_nic: expectations are queued with the stimulus and popped at each check.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    cardinal_nic dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [63:0] v);
        sb_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] exp_v;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            exp_v = sb_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
            $display("check %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_chk(input string tag, input logic [63:0] exp_v, input logic [63:0] obs);
        expect_val(exp_v);
        chk(tag, obs);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [63:0] exp_v, input string tag, input bit do_tick);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        #1;
        expect_val(exp_v);
        chk(tag, d_out);
        if (do_tick) tick();
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] v);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0; d_in = '0;
    endtask

    initial begin
        rst = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        #12;
        exp_chk("reset_ri", 64'd1, {63'd0, net_ri});
        exp_chk("reset_so", 64'd0, {63'd0, net_so});
        exp_chk("reset_do", 64'd0, net_do);
        exp_chk("reset_dout", 64'd0, d_out);
        tick();
        rst = 1'b0;
        tick();

        // Receive path
        net_si = 1'b1; net_di = 64'h8000_0000_0000_00AB;
        tick();
        net_si = 1'b0; net_di = '0;
        #1 exp_chk("rx_ri_low", 64'd0, {63'd0, net_ri});
        rd_chk(2'b01, 64'd1, "rx_stat_full", 1'b0);
        tick();
        rd_chk(2'b00, 64'h8000_0000_0000_00AB, "rx_buf_read", 1'b1);
        rd_chk(2'b01, 64'd0, "rx_stat_empty", 1'b0);
        exp_chk("rx_ri_high", 64'd1, {63'd0, net_ri});
        rd_chk(2'b10, 64'd0, "tx_buf_read_zero", 1'b0);
        tick();

        // Back-pressure
        net_si = 1'b1; net_di = 64'h1111;
        tick();
        net_di = 64'h1234;
        tick();
        net_si = 1'b0; net_di = '0;
        rd_chk(2'b00, 64'h1111, "bp_keep_old", 1'b1);
        net_si = 1'b1; net_di = 64'h1234;
        tick();
        net_si = 1'b0; net_di = '0;
        rd_chk(2'b00, 64'h1234, "bp_second", 1'b1);

        // Transmit, VC 0: send only while polarity = 1
        net_ro = 1'b1; net_polarity = 1'b0;
        wr(2'b10, 64'h55);
        #1 exp_chk("vc0_so_pol0", 64'd0, {63'd0, net_so});
        exp_chk("vc0_do", 64'h55, net_do);
        net_polarity = 1'b1;
        #1 exp_chk("vc0_so_pol1", 64'd1, {63'd0, net_so});
        tick();
        rd_chk(2'b11, 64'd0, "vc0_tx_stat", 1'b0);
        exp_chk("vc0_so_after", 64'd0, {63'd0, net_so});

        // Transmit, VC 1: send only while polarity = 0
        net_polarity = 1'b1;
        wr(2'b10, 64'h8000_0000_0000_0055);
        #1 exp_chk("vc1_so_pol1", 64'd0, {63'd0, net_so});
        net_polarity = 1'b0;
        #1 exp_chk("vc1_so_pol0", 64'd1, {63'd0, net_so});
        exp_chk("vc1_do", 64'h8000_0000_0000_0055, net_do);
        tick();
        rd_chk(2'b11, 64'd0, "vc1_tx_stat", 1'b0);

        // Tx full and stall: second write ignored
        net_ro = 1'b0; net_polarity = 1'b1;
        wr(2'b10, 64'hA);
        wr(2'b10, 64'hB);
        #1 exp_chk("stall_do", 64'hA, net_do);
        exp_chk("stall_so", 64'd0, {63'd0, net_so});
        rd_chk(2'b11, 64'd1, "stall_tx_stat", 1'b0);
        net_ro = 1'b1;
        #1 exp_chk("stall_release_so", 64'd1, {63'd0, net_so});
        exp_chk("stall_release_do", 64'hA, net_do);
        tick();
        exp_chk("stall_b_dropped_so", 64'd0, {63'd0, net_so});
        exp_chk("stall_b_dropped_do", 64'd0, net_do);

        // Write racing a drain is dropped
        net_ro = 1'b0;
        wr(2'b10, 64'hC1);
        net_ro = 1'b1;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'hC2;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0; d_in = '0;
        rd_chk(2'b11, 64'd0, "race_write_dropped", 1'b0);

        // Concurrent rx capture and tx drain
        net_ro = 1'b0;
        wr(2'b10, 64'hC);
        net_si = 1'b1; net_di = 64'h77; net_ro = 1'b1; net_polarity = 1'b1;
        #1 exp_chk("conc_so", 64'd1, {63'd0, net_so});
        tick();
        net_si = 1'b0; net_di = '0; net_ro = 1'b0;
        rd_chk(2'b01, 64'd1, "conc_rx_stat", 1'b0);
        rd_chk(2'b11, 64'd0, "conc_tx_stat", 1'b0);
        tick();
        rd_chk(2'b00, 64'h77, "conc_rx_buf", 1'b1);

        // Asynchronous reset with both buffers full
        wr(2'b10, 64'hD);
        net_si = 1'b1; net_di = 64'h99;
        tick();
        net_si = 1'b0; net_di = '0;
        net_ro = 1'b1; net_polarity = 1'b1;
        #1 exp_chk("pre_rst_so", 64'd1, {63'd0, net_so});
        exp_chk("pre_rst_ri", 64'd0, {63'd0, net_ri});
        rst = 1'b1;
        #1 exp_chk("rst_ri", 64'd1, {63'd0, net_ri});
        exp_chk("rst_so", 64'd0, {63'd0, net_so});
        exp_chk("rst_do", 64'd0, net_do);
        tick();
        rst = 1'b0;
        net_ro = 1'b0;
        rd_chk(2'b01, 64'd0, "rst_rx_stat", 1'b0);
        rd_chk(2'b11, 64'd0, "rst_tx_stat", 1'b0);
        tick();

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
